// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC and drives the instruction SRAM.
// A taken branch seen while stalled is parked so the redirect is not lost.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic [32:0] if_to_id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  output logic        fetch_adel,
  output logic [31:0] fetch_count
);

  // Encoding is {ce_reg, redir_pend}.
  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b10,
    HOLD = 2'b11
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc_reg, pc_nx;
  logic [31:0] redir_addr, redir_nx;
  logic [31:0] cnt, cnt_nx;
  logic        ce_reg;
  logic        br_e;
  logic [31:0] br_addr;
  logic        stop;
  logic        unused_stall;

  assign br_e         = br_bus[32];
  assign br_addr      = br_bus[31:0];
  assign stop         = stall[0];
  assign unused_stall = ^stall[5:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc_reg     <= RESET_PC - 32'd4;
      redir_addr <= 32'd0;
      cnt        <= 32'd0;
    end else begin
      state      <= state_nx;
      pc_reg     <= pc_nx;
      redir_addr <= redir_nx;
      cnt        <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_reg;
    redir_nx = redir_addr;
    cnt_nx   = cnt;
    unique case (state)
      BOOT: begin
        state_nx = RUN;
        pc_nx    = RESET_PC;
      end
      RUN: begin
        if (!stop) begin
          pc_nx  = br_e ? br_addr : pc_reg + 32'd4;
          cnt_nx = cnt + 32'd1;
        end else if (br_e) begin
          redir_nx = br_addr;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (!stop) begin
          // A live branch outranks the parked one.
          pc_nx    = br_e ? br_addr : redir_addr;
          cnt_nx   = cnt + 32'd1;
          state_nx = RUN;
        end else if (br_e) begin
          redir_nx = br_addr;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

  assign ce_reg          = (state != BOOT);
  assign fetch_adel      = ce_reg & (pc_reg[1:0] != 2'b00);
  assign inst_sram_en    = ce_reg & ~fetch_adel;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wdata = 32'd0;
  assign if_to_id_bus    = {ce_reg, pc_reg};
  assign fetch_count     = cnt;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboarded testbench for if_fetch: directed scenarios then random
// stall/branch traffic against a behavioural fetch model.
module tb_if_fetch;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic [32:0] br_bus = '0;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        fetch_adel;
  logic [31:0] fetch_count;

  if_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .br_bus(br_bus),
    .if_to_id_bus(if_to_id_bus),
    .inst_sram_en(inst_sram_en),
    .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .fetch_adel(fetch_adel),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [32:0] bus;
    logic        en;
    logic        adel;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails = 0;

  // Model: fetch enabled flag, pc, count, and at most one parked target.
  bit          m_on;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_park[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.bus  = {m_on, m_pc};
    e.adel = m_on && (m_pc % 4 != 0);
    e.en   = m_on && (m_pc % 4 == 0);
    e.cnt  = m_cnt;
    return e;
  endfunction

  task automatic model_reset();
    m_on  = 0;
    m_pc  = RPC - 4;
    m_cnt = 0;
    m_park.delete();
  endtask

  task automatic model_edge(bit stop, bit be, logic [31:0] ba);
    if (!m_on) begin
      m_on = 1;
      m_pc = RPC;
    end else if (!stop) begin
      if (be) m_pc = ba;
      else if (m_park.size() != 0) m_pc = m_park[0];
      else m_pc = m_pc + 4;
      m_park.delete();
      m_cnt = m_cnt + 1;
    end else if (be) begin
      m_park.delete();
      m_park.push_back(ba);
    end
  endtask

  task automatic step(logic [5:0] s, logic [32:0] b);
    @(negedge clk);
    stall  = s;
    br_bus = b;
    model_edge(s[0], b[32], b[31:0]);
    sb.push_back(model_out());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_pc(string name, logic [31:0] pc);
    settle();
    chk(name, {31'd0, if_to_id_bus}, {31'd0, 1'b1, pc});
  endtask

  task automatic chk_reset_vals(string name);
    chk({name, "_bus"}, {31'd0, if_to_id_bus}, {31'd0, 33'h0_BFBF_FFFC});
    chk({name, "_en"}, {63'd0, inst_sram_en}, 64'd0);
    chk({name, "_cnt"}, {32'd0, fetch_count}, 64'd0);
  endtask

  // Reset pulse between edges; the following edge is the boot edge.
  task automatic async_reset(logic [5:0] s, logic [32:0] b);
    @(negedge clk);
    stall  = s;
    br_bus = b;
    rst    = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    rst = 1'b0;
    model_reset();
    model_edge(s[0], b[32], b[31:0]);
    sb.push_back(model_out());
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("sb_bus", {31'd0, if_to_id_bus}, {31'd0, e.bus});
      chk("sb_en", {63'd0, inst_sram_en}, {63'd0, e.en});
      chk("sb_adel", {63'd0, fetch_adel}, {63'd0, e.adel});
      chk("sb_cnt", {32'd0, fetch_count}, {32'd0, e.cnt});
      chk("sb_addr", {32'd0, inst_sram_addr}, {32'd0, e.bus[31:0]});
      chk("sb_tie", {28'd0, inst_sram_wen, inst_sram_wdata},
          64'd0);
    end
  end

  initial begin
    logic [31:0] a;
    logic [5:0]  s;
    bit          be;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    chk("reset_adel", {63'd0, fetch_adel}, 64'd0);
    rst = 1'b0;

    step(6'd0, 33'd0);
    chk_pc("boot_pc", RPC);
    chk("boot_cnt", {32'd0, fetch_count}, 64'd0);
    step(6'd0, 33'd0);
    chk_pc("first_adv", RPC + 4);
    chk("first_cnt", {32'd0, fetch_count}, 64'd1);
    repeat (3) step(6'd0, 33'd0);
    step(6'd0, {1'b1, 32'hBFC0_0100});
    chk_pc("live_br", 32'hBFC0_0100);
    step(6'd0, 33'd0);
    chk_pc("live_br_next", 32'hBFC0_0104);

    step(6'b000011, {1'b1, 32'hBFC0_0200});
    step(6'b000011, 33'd0);
    step(6'b000011, 33'd0);
    chk_pc("stall_hold", 32'hBFC0_0104);
    step(6'd0, 33'd0);
    chk_pc("stall_redir", 32'hBFC0_0200);
    chk("stall_cnt", {32'd0, fetch_count}, 64'd7);

    step(6'd1, {1'b1, 32'h0000_0100});
    step(6'd1, {1'b1, 32'h0000_0300});
    step(6'd0, 33'd0);
    chk_pc("overwrite", 32'h0000_0300);
    step(6'd1, {1'b1, 32'h0000_0100});
    step(6'd0, {1'b1, 32'h0000_0400});
    chk_pc("live_prio", 32'h0000_0400);
    step(6'd0, 33'd0);
    chk_pc("pend_clear", 32'h0000_0404);

    step(6'd0, {1'b1, 32'h0000_0002});
    chk_pc("misalign_pc", 32'h0000_0002);
    chk("misalign_adel", {63'd0, fetch_adel}, 64'd1);
    chk("misalign_en", {63'd0, inst_sram_en}, 64'd0);
    step(6'd0, 33'd0);
    chk_pc("misalign_adv", 32'h0000_0006);
    step(6'd0, {1'b1, 32'hFFFF_FFFC});
    step(6'd0, 33'd0);
    chk_pc("wrap", 32'h0000_0000);

    step(6'd1, {1'b1, 32'h0000_0500});
    step(6'd1, 33'd0);
    async_reset(6'd1, {1'b1, 32'h0000_0500});
    chk_pc("rst_boot", RPC);
    step(6'd0, 33'd0);
    chk_pc("rst_no_redir", RPC + 4);

    for (int i = 0; i < 600; i++) begin
      s  = 6'($urandom);
      be = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = $urandom & 32'hFFFF_FFFC;
        2: a = 32'hFFFF_FFF8;
        default: a = RPC + ($urandom_range(0, 255) << 2);
      endcase
      if ($urandom_range(0, 99) == 0) async_reset(s, {be, a});
      else step(s, {be, a});
    end

    settle();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage MIPS pipeline: owns the architectural fetch PC, drives the instruction SRAM request, and hands `{ce, pc}` to the decode stage over `if_to_id_bus`. It is the consumer of the decode stage's `br_bus` redirect. It remembers a taken branch that arrives while fetch is stalled, so the redirect is never lost. It also flags misaligned fetch addresses and keeps a retired-fetch counter for performance monitoring.

## Interface
- `RESET_PC`, 32'hBFC0_0000, first PC fetched after reset
- `clk` input 1: single pipeline clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `stall` input `StallBus` (6): stall vector; `stall[0]` is the PC stage, where 1 = `Stop` and 0 = `NoStop`
- `br_bus` input `BR_WD` (33): `{br_e[32], br_addr[31:0]}` from decode
- `if_to_id_bus` output `IF_TO_ID_WD` (33): `{ce[32], pc[31:0]}`
- `inst_sram_en` output 1: instruction SRAM read enable
- `inst_sram_wen` output 4: tied to 4'b0000
- `inst_sram_addr` output 32: fetch address
- `inst_sram_wdata` output 32: tied to 32'b0
- `fetch_adel` output 1: current fetch PC is misaligned
- `fetch_count` output 32: number of PC advances since reset

## Operation
- Registers:
  - `pc_reg` (32), `ce_reg` (1)
  - `redir_pend` (1), `redir_addr` (32)
  - `cnt` (32)
- State is implied by two bits:
  - BOOT: `ce_reg`=0
  - RUN: `ce_reg`=1, `redir_pend`=0
  - HOLD: `ce_reg`=1, `redir_pend`=1
- Next-PC selection, priority order:
  1. live `br_e` → `br_addr`
  2. `redir_pend` → `redir_addr`
  3. otherwise `pc_reg + 4`, wrapping modulo 2^32 (0xFFFF_FFFC + 4 = 0)
- BOOT → RUN: on the first clock edge after `rst` falls, regardless of `stall`:
  - `ce_reg` <= 1
  - `pc_reg` <= `RESET_PC`
  - `br_e` is ignored in BOOT.
- RUN, `stall[0]`=0: `pc_reg` <= next PC; `cnt` += 1.
- RUN, `stall[0]`=1:
  - `pc_reg` and `cnt` hold.
  - If `br_e`=1: `redir_addr` <= `br_addr`, `redir_pend` <= 1, and the block moves to HOLD.
- HOLD, `stall[0]`=1:
  - `pc_reg` holds.
  - A further `br_e`=1 overwrites `redir_addr`; the last redirect wins.
- HOLD, `stall[0]`=0:
  - `pc_reg` <= next PC, which is the live `br_addr` if `br_e`=1, else `redir_addr`.
  - `redir_pend` <= 0; `cnt` += 1; return to RUN.
- Outputs:
  - `inst_sram_addr` = `pc_reg`
  - `if_to_id_bus` = `{ce_reg, pc_reg}`
  - `fetch_adel` = `ce_reg & (pc_reg[1:0] != 0)`
  - `inst_sram_en` = `ce_reg & ~fetch_adel`
- A misaligned PC still advances normally; exception handling is downstream.

## Timing
- Reset values, asserted asynchronously on `rst`=1 and held while high:
  - `pc_reg` = `RESET_PC` − 4 (0xBFBF_FFFC)
  - `ce_reg`=0, `redir_pend`=0, `redir_addr`=0, `cnt`=0
  - hence `inst_sram_en`=0, `fetch_adel`=0, `if_to_id_bus`=33'h0_BFBF_FFFC, `fetch_count`=0
- Reset asserted mid-HOLD discards the pending redirect immediately, with no clock needed.
- The SRAM is synchronous read: instruction data for `inst_sram_addr` in cycle N is valid in cycle N+1. The decode stage registers `if_to_id_bus` in the same edge, so pc and data align.
- Redirect latency: `br_e` sampled at edge N with `stall[0]`=0 gives `pc_reg` = `br_addr` after edge N.
- The instruction already fetched at the time of the redirect (pc+4) is the delay slot and is not squashed here.
- All outputs are combinational from registers only; there is no input→output combinational path.
- `cnt` wraps from 0xFFFF_FFFF to 0.

## Test plan
- **Reset/boot:** hold `rst` 3 cycles, then release with `stall`=0 → `if_to_id_bus`=33'h0_BFBF_FFFC and `inst_sram_en`=0 during reset. After the first edge, `ce`=1, `pc`=0xBFC0_0000, `fetch_count`=0. After the next edge, `pc`=0xBFC0_0004 and `fetch_count`=1.
- **Live redirect:** at `pc`=0xBFC0_0010, drive `br_bus`={1, 0xBFC0_0100} for one cycle with no stall → next `pc`=0xBFC0_0100, then 0xBFC0_0104.
- **Redirect during stall:** `stall`=6'b000011 for 3 cycles, with `br_e`=1, `br_addr`=0xBFC0_0200 in the first stalled cycle only → `pc` holds through the stall. After release, `pc`=0xBFC0_0200 and `fetch_count` advances by exactly 1.
- **Overwrite and priority:**
  - In HOLD with `redir_addr`=0x100, a second stalled `br_e` with 0x300 → 0x300 wins.
  - Separately, a release cycle with live `br_e`=0x400 while 0x100 is pending → `pc`=0x400 and the pending redirect is cleared.
- **Misalign/wrap:** branch to 0x0000_0002 → `fetch_adel`=1 and `inst_sram_en`=0 while `pc`=2, then `pc`=6. A branch to 0xFFFF_FFFC → next `pc`=0x0000_0000.
- **Async reset mid-HOLD:** pulse `rst` between edges while `redir_pend`=1 → outputs return to reset values before the next edge. After release, fetch resumes at 0xBFC0_0000, not at `redir_addr`.
